// File: rtl/hiscore_ioctl_pkg.sv
// Shared types and constants for the hiscore ioctl loader-side master.
// Optional checksum build: define HISCORE_IOCTL_CHECKSUM_EN.
package hiscore_ioctl_pkg;

    localparam int ADDR_W_DEF = 25;
    localparam int TIMER_W    = 8;

    localparam logic [7:0] IDX_HISCORE_CFG  = 8'd3;
    localparam logic [7:0] IDX_HISCORE_DATA = 8'd4;

    typedef enum logic [2:0] {
        IDLE,
        DL_WAIT,
        DL_WR,
        DL_GAP,
        DL_TAIL,
        UL_SETTLE,
        UL_OUT,
        FIN
    } state_t;

endpackage

// File: rtl/hiscore_ioctl_timer.sv
// Loadable down-counter with zero flag for write gaps and read latency.
module hiscore_ioctl_timer
    import hiscore_ioctl_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hiscore_ioctl_master.sv
// Loader-side ioctl master: streams host bytes to the core or reads them back.
// Define HISCORE_IOCTL_CHECKSUM_EN to enable the running 8-bit checksum.
module hiscore_ioctl_master
    import hiscore_ioctl_pkg::*;
#(
    parameter int WR_GAP = 2,
    parameter int RD_LAT = 3,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_upload,
    input  logic [7:0]        cmd_index,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              cmd_abort,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    output logic              snk_valid,
    output logic [7:0]        snk_data,
    input  logic              snk_ready,
    output logic              done,
    output logic [7:0]        checksum,
    output logic              ioctl_download,
    output logic              ioctl_upload,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_index,
    input  logic [7:0]        ioctl_din
);

    // DL_WAIT supplies one idle cycle, so the gap state covers the rest
    localparam logic [TIMER_W-1:0] GAP_LOAD =
        (WR_GAP > 1) ? TIMER_W'(WR_GAP - 2) : '0;
    localparam logic [TIMER_W-1:0] LAT_LOAD = TIMER_W'(RD_LAT);
    localparam logic [ADDR_W-1:0]  ONE      = ADDR_W'(1);

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_val;
    logic                tmr_en;
    logic                tmr_zero;
    logic                accept;
    logic                abort_now;
    logic                ul_take;

    assign accept    = (state == IDLE) && cmd_ready && cmd_valid;
    assign abort_now = cmd_abort && (state != IDLE) && (state != FIN);
    assign src_ready = (state == DL_WAIT) && !cmd_abort;
    assign ul_take   = (state == UL_OUT) && snk_ready && !cmd_abort;

    assign tmr_load = (state == IDLE) || (state == DL_WR) || ul_take;
    assign tmr_val  = (state == DL_WR) ? GAP_LOAD : LAT_LOAD;
    assign tmr_en   = (state == DL_GAP) || (state == UL_SETTLE);

    hiscore_ioctl_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            cmd_ready      <= 1'b0;
            snk_valid      <= 1'b0;
            snk_data       <= '0;
            done           <= 1'b0;
            ioctl_download <= 1'b0;
            ioctl_upload   <= 1'b0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= '0;
            ioctl_index    <= '0;
        end else begin
            done     <= 1'b0;
            ioctl_wr <= 1'b0;
            if (abort_now) begin
                ioctl_download <= 1'b0;
                ioctl_upload   <= 1'b0;
                snk_valid      <= 1'b0;
                done           <= 1'b1;
                state          <= FIN;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            cmd_ready   <= 1'b0;
                            cnt         <= cmd_len;
                            ioctl_addr  <= '0;
                            ioctl_index <= cmd_index;
                            if (cmd_len == '0) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else if (cmd_upload) begin
                                ioctl_upload <= 1'b1;
                                state        <= UL_SETTLE;
                            end else begin
                                ioctl_download <= 1'b1;
                                state          <= DL_WAIT;
                            end
                        end else begin
                            cmd_ready <= 1'b1;
                        end
                    end
                    DL_WAIT: begin
                        if (src_valid) begin
                            ioctl_dout <= src_data;
                            ioctl_wr   <= 1'b1;
                            state      <= DL_WR;
                        end
                    end
                    DL_WR: begin
                        state <= DL_GAP;
                    end
                    DL_GAP: begin
                        if (tmr_zero) begin
                            cnt <= cnt - ONE;
                            if (cnt != ONE) begin
                                ioctl_addr <= ioctl_addr + ONE;
                                state      <= DL_WAIT;
                            end else begin
                                state <= DL_TAIL;
                            end
                        end
                    end
                    DL_TAIL: begin
                        ioctl_download <= 1'b0;
                        done           <= 1'b1;
                        state          <= FIN;
                    end
                    UL_SETTLE: begin
                        if (tmr_zero) begin
                            snk_data  <= ioctl_din;
                            snk_valid <= 1'b1;
                            state     <= UL_OUT;
                        end
                    end
                    UL_OUT: begin
                        if (snk_ready) begin
                            snk_valid <= 1'b0;
                            cnt       <= cnt - ONE;
                            if (cnt != ONE) begin
                                ioctl_addr <= ioctl_addr + ONE;
                                state      <= UL_SETTLE;
                            end else begin
                                ioctl_upload <= 1'b0;
                                done         <= 1'b1;
                                state        <= FIN;
                            end
                        end
                    end
                    FIN: begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef HISCORE_IOCTL_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (src_ready && src_valid) begin
            checksum <= checksum + src_data;
        end else if (ul_take) begin
            checksum <= checksum + snk_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: doc/hiscore_ioctl_master.md
Name: hiscore_ioctl_master

Overview:
- Drives the ioctl interface from the loader side: the counterpart of the hiscore capture/readback logic.
- Download: streams host bytes into the core as ioctl_wr strobes at incrementing ioctl_addr under a selected ioctl_index. Used for index 3 (hiscore table) and index 4 (hiscore data).
- Upload: walks ioctl_addr from 0, waits the core's read latency, samples ioctl_din and returns each byte to the host.
- Sits between the simulation/host file bridge and the core's ioctl bus.

Parameters:
- WR_GAP, 2, idle cycles inserted after every ioctl_wr pulse (min 1).
- RD_LAT, 3, cycles from an ioctl_addr change to valid ioctl_din during upload (min 1).
- ADDR_W, 25, ioctl address width.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request, accepted when cmd_ready.
- cmd_ready  out  1  high only in IDLE.
- cmd_upload  in  1  0=download, 1=upload.
- cmd_index  in  8  ioctl_index for the transfer.
- cmd_len  in  ADDR_W  byte count.
- cmd_abort  in  1  terminate the current transfer.
- src_valid  in  1  download byte available.
- src_data  in  8  download byte.
- src_ready  out  1  download byte accepted.
- snk_valid  out  1  upload byte available.
- snk_data  out  8  upload byte.
- snk_ready  in  1  host takes the upload byte.
- done  out  1  one-cycle pulse at end of a transfer (normal or aborted).
- checksum  out  8  see Optional Feature.
- ioctl_download  out  1
- ioctl_upload  out  1
- ioctl_wr  out  1
- ioctl_addr  out  ADDR_W
- ioctl_dout  out  8
- ioctl_index  out  8
- ioctl_din  in  8

Behaviour:
- Reset: all outputs 0; state IDLE; cmd_ready asserts in the first cycle after reset release.
- All outputs registered.
- ioctl_index latches at command accept and holds until the next accept. It stays stable after ioctl_download falls, so the core can qualify the falling edge with the index.
- States: IDLE, DL_WAIT, DL_WR, DL_GAP, DL_TAIL, UL_SETTLE, UL_OUT, FIN.
- IDLE, on accept: cnt<=cmd_len; ioctl_addr<=0.
  - cmd_len==0: go to FIN; no ioctl activity.
  - Download: ioctl_download<=1; go to DL_WAIT.
  - Upload: ioctl_upload<=1; go to UL_SETTLE with timer=RD_LAT.
- DL_WAIT: src_ready=1 combinationally. On src_valid: ioctl_dout<=src_data, ioctl_wr<=1 next cycle, go to DL_WR.
- DL_WR: ioctl_wr high exactly one cycle; ioctl_addr and ioctl_dout stable during it. Next state DL_GAP with timer=WR_GAP.
- DL_GAP: ioctl_wr=0.
  - At timer expiry: cnt-=1; ioctl_addr+=1 only if cnt!=0.
  - Then DL_WAIT if bytes remain, else DL_TAIL.
  - The last write's address stays on the bus.
- DL_TAIL: one cycle; ioctl_download<=0, then FIN.
- UL_SETTLE: timer counts down at a stable ioctl_addr. At 0: snk_data<=ioctl_din, snk_valid<=1, go to UL_OUT.
- UL_OUT: hold snk_valid/snk_data until snk_ready.
  - On handshake: cnt-=1.
  - If cnt!=0: ioctl_addr+=1, timer=RD_LAT, back to UL_SETTLE.
  - Else ioctl_upload<=0, FIN.
  - ioctl_addr changes exactly once per byte and never skips.
- FIN: done=1 for one cycle; IDLE.
- cmd_abort, any non-IDLE state:
  - Next cycle ioctl_wr, snk_valid, ioctl_download and ioctl_upload go 0; then FIN.
  - An ioctl_wr pulse already in DL_WR completes its single cycle.
- cmd_valid while busy is ignored: cmd_ready=0.
- Address arithmetic wraps modulo 2^ADDR_W; cmd_len is never larger.
- Asynchronous reset mid-transfer: every strobe drops immediately; no done pulse.

Optional Feature:
- HISCORE_IOCTL_CHECKSUM_EN defined:
  - checksum = 8-bit wrapping sum of every byte written (download) or delivered (upload).
  - Cleared at command accept; valid on the done pulse; held until the next accept.
- Undefined: checksum tied to 0; no adder logic.

Decomposition:
- Package hiscore_ioctl_pkg: state enum type; IDX_HISCORE_CFG=8'd3 and IDX_HISCORE_DATA=8'd4 constants; ADDR_W default.
- One sub-module, hiscore_ioctl_timer: loadable down-counter with a zero flag, shared by the WR_GAP and RD_LAT waits.

Test Plan:
- Reset release: all ioctl outputs 0 and cmd_ready=1 at cycle 1.
- Download index 3, len 16, bytes 00 00 00 0b 0f 10 01 00 / 00 00 00 23 0f 04 12 00, src always valid:
  - 16 single-cycle ioctl_wr pulses at addr 0..15, spaced 1+WR_GAP cycles.
  - ioctl_download falls one cycle after the final gap; ioctl_index stays 3; done pulses once.
- Download index 4, len 5, src_valid toggling every other cycle: exactly 5 writes with correct dout; no write while src_valid=0.
- Upload len 4, model core returning din=addr+8'hA0 after RD_LAT=3:
  - snk bytes A0 A1 A2 A3; addr sequence 0,1,2,3, each held ≥3 cycles.
  - snk_ready stalls of 5 cycles hold snk_data and addr stable.
- cmd_len=0 download: no ioctl_download or ioctl_wr; done one cycle after accept.
- cmd_abort at the 3rd write of a len 8 download: ioctl_wr pulse completes; download drops next cycle; done pulses; ioctl_addr=2.
- (Checksum build) download bytes 0x80,0x90: checksum=0x10 at done.
